or_job_sequencer: RTL

Upstream bus master for the 1-bit OR accelerator register map. It accepts (a, b) operand jobs on a valid/ready stream and drives the accelerator's write/read bus. For each job it polls status, writes both operands, polls for a result, pops it, and presents the result on an output valid/ready stream. One job is in flight at a time. A poll timeout and a completed-job counter support bring-up and debug.

---
 rtl/or_job_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/or_job_sequencer.sv
// rtl/or_job_sequencer.sv - bus master that runs (a, b) jobs through the 1-bit OR accelerator
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i/in_ready_o         operand job stream, operands in_a_i / in_b_i
//   out_valid_o/out_ready_i       result stream, result out_y_o
//   write_address_o/write_data_o/write_en_o/write_rdy_i   accelerator write bus
//   read_address_o/read_en_o/read_data_i/read_rdy_i       accelerator read bus
//   err_o                         sticky poll-timeout flag
//   jobs_done_o                   completed-job counter (wraps)
module or_job_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_a_i,
  input  logic        in_b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_y_o,
  output logic [2:0]  write_address_o,
  output logic        write_data_o,
  output logic        write_en_o,
  input  logic        write_rdy_i,
  output logic [2:0]  read_address_o,
  output logic        read_en_o,
  input  logic        read_data_i,
  input  logic        read_rdy_i,
  output logic        err_o,
  output logic [15:0] jobs_done_o
);

  typedef enum logic [3:0] {
    IDLE, POLL_A, WR_A, POLL_B, WR_B, SETTLE, POLL_Y, RD_Y, OUT
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [7:0] SETTLE_C  = 8'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;      // poll count in poll states, idle count in SETTLE
  logic        timeout_hit;
  logic        accept;
  logic        op_a_q, op_b_q;
  logic        in_ready_q, out_valid_q, out_y_q, err_q;
  logic        write_en_q, write_data_q, read_en_q;
  logic [2:0]  write_address_q, read_address_q;
  logic [15:0] jobs_done_q;

  // in_ready_q is low for the first cycle after reset, so no job can be
  // accepted before the sequencer advertises readiness.
  assign accept = (state_q == IDLE) && in_valid_i && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = POLL_A;
          cnt_d   = 8'd0;
        end
      end
      POLL_A, POLL_B, POLL_Y: begin
        if (read_rdy_i) begin
          if (read_data_i) begin
            state_d = (state_q == POLL_A) ? WR_A : (state_q == POLL_B) ? WR_B : RD_Y;
            cnt_d   = 8'd0;
          end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
            // Give up on the job; it is not counted as done.
            timeout_hit = 1'b1;
            state_d     = IDLE;
            cnt_d       = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      WR_A: begin
        if (write_rdy_i) begin
          state_d = POLL_B;
          cnt_d   = 8'd0;
        end
      end
      WR_B: begin
        if (write_rdy_i) begin
          state_d = SETTLE;
          cnt_d   = 8'd0;
        end
      end
      SETTLE: begin
        // Gives the accelerator time to enqueue the result before polling.
        if (cnt_q == SETTLE_C - 8'd1) begin
          state_d = POLL_Y;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD_Y: begin
        if (read_rdy_i) state_d = OUT;
      end
      OUT: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q
  // and never depend combinationally on an input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      cnt_q           <= 8'd0;
      op_a_q          <= 1'b0;
      op_b_q          <= 1'b0;
      in_ready_q      <= 1'b0;
      out_valid_q     <= 1'b0;
      out_y_q         <= 1'b0;
      err_q           <= 1'b0;
      jobs_done_q     <= 16'd0;
      write_en_q      <= 1'b0;
      write_data_q    <= 1'b0;
      write_address_q <= 3'd0;
      read_en_q       <= 1'b0;
      read_address_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_a_q <= in_a_i;
        op_b_q <= in_b_i;
      end
      if (state_q == RD_Y && read_rdy_i) out_y_q <= read_data_i;
      if (state_q == OUT && out_ready_i) jobs_done_q <= jobs_done_q + 16'd1;
      err_q       <= err_q | timeout_hit;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == OUT);

      write_en_q      <= 1'b0;
      write_data_q    <= 1'b0;
      write_address_q <= 3'd0;
      read_en_q       <= 1'b0;
      read_address_q  <= 3'd0;
      case (state_d)
        POLL_A: begin read_en_q <= 1'b1; read_address_q <= 3'd0; end
        POLL_B: begin read_en_q <= 1'b1; read_address_q <= 3'd1; end
        POLL_Y: begin read_en_q <= 1'b1; read_address_q <= 3'd2; end
        RD_Y:   begin read_en_q <= 1'b1; read_address_q <= 3'd3; end
        WR_A: begin
          write_en_q      <= 1'b1;
          write_address_q <= 3'd4;
          write_data_q    <= op_a_q;
        end
        WR_B: begin
          write_en_q      <= 1'b1;
          write_address_q <= 3'd5;
          write_data_q    <= op_b_q;
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o      = in_ready_q;
  assign out_valid_o     = out_valid_q;
  assign out_y_o         = out_y_q;
  assign err_o           = err_q;
  assign jobs_done_o     = jobs_done_q;
  assign write_en_o      = write_en_q;
  assign write_data_o    = write_data_q;
  assign write_address_o = write_address_q;
  assign read_en_o       = read_en_q;
  assign read_address_o  = read_address_q;

endmodule
